// File: rtl/fv_core_if_queue_sched.sv
// Push/pop scheduler for the FV IF instruction queue: tracks occupancy and
// sequences REFILL -> RUN -> DRAIN -> DONE, with kill/stall handling.
module fv_core_if_queue_sched #(
  parameter int MAX_INSTR = 2,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic                 stall,
  input  logic                 kill,
  input  logic                 kill_is_cf,
  input  logic                 drain_req,
  input  logic [MAX_INSTR-1:0] gen_valid,
  output logic [MAX_INSTR-1:0] gen_ready,
  input  logic [MAX_INSTR-1:0] fetch_req,
  output logic [MAX_INSTR-1:0] queue_push,
  output logic [MAX_INSTR-1:0] queue_pop,
  output logic [MAX_INSTR-1:0] is_empty,
  output logic [CNT_W-1:0]     count,
  output logic [1:0]           state,
  output logic                 proto_err
);

  typedef enum logic [1:0] {
    S_REFILL = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam int SW = CNT_W + 2;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 proto_err_q, proto_err_d;

  logic                 kill_int, accept_st, pop_st, fetch_run, ovf;
  logic signed [SW-1:0] count_s, free_s, push_cnt, pop_cnt, avail, sum, count_nx;

  function automatic logic is_prefix(input logic [MAX_INSTR-1:0] v);
    logic seen_zero;
    is_prefix = 1'b1;
    seen_zero = 1'b0;
    for (int i = 0; i < MAX_INSTR; i++) begin
      if (!v[i]) seen_zero = 1'b1;
      else if (seen_zero) is_prefix = 1'b0;
    end
  endfunction

  function automatic logic signed [SW-1:0] popcnt(input logic [MAX_INSTR-1:0] v);
    popcnt = '0;
    for (int i = 0; i < MAX_INSTR; i++)
      popcnt = popcnt + $signed({{(SW-1){1'b0}}, v[i]});
  endfunction

  always_comb begin
    kill_int  = kill & kill_is_cf;
    accept_st = (state_q == S_REFILL) || (state_q == S_RUN);
    pop_st    = (state_q == S_RUN) || (state_q == S_DRAIN);
    count_s   = $signed({2'b00, count_q});
    // Free space ignores same-cycle pops, so a full queue never accepts.
    free_s    = $signed(SW'(DEPTH - 1)) - count_s;
    for (int i = 0; i < MAX_INSTR; i++)
      gen_ready[i] = !stall & accept_st & !drain_req & ($signed(SW'(i)) < free_s);
    queue_push = gen_valid & gen_ready;
    push_cnt   = popcnt(queue_push);
    avail      = count_s + push_cnt;
    fetch_run  = 1'b1;
    for (int i = 0; i < MAX_INSTR; i++) begin
      fetch_run    = fetch_run & fetch_req[i];
      queue_pop[i] = pop_st & !stall & !kill_int & fetch_run & ($signed(SW'(i)) < avail);
      is_empty[i]  = !pop_st | kill_int | ($signed(SW'(i)) >= avail);
    end
    pop_cnt = popcnt(queue_pop);
    sum     = avail - pop_cnt;

    // Pushes accepted in a kill cycle belong to the redirected path.
    if (kill_int)    count_nx = stall ? '0 : push_cnt;
    else if (!stall) count_nx = sum;
    else             count_nx = count_s;
    count_d = CNT_W'(count_nx);

    ovf = !kill_int & !stall & ((sum > $signed(SW'(DEPTH - 1))) | sum[SW-1]);
    proto_err_d = proto_err_q | !is_prefix(gen_valid) | !is_prefix(fetch_req) | ovf;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REFILL: begin
        if (drain_req)
          state_d = S_DRAIN;
        else if (!kill_int && ((count_nx >= $signed(SW'(MAX_INSTR))) ||
                               ((count_nx != '0) && (gen_valid == '0))))
          state_d = S_RUN;
      end
      S_RUN: begin
        if (drain_req)     state_d = S_DRAIN;
        else if (kill_int) state_d = S_REFILL;
      end
      S_DRAIN: begin
        if (kill_int || (!stall && (sum == '0))) state_d = S_DONE;
      end
      default: state_d = S_DONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      count_q     <= '0;
      state_q     <= S_REFILL;
      proto_err_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      state_q     <= state_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign count     = count_q;
  assign state     = state_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_fv_core_if_queue_sched.sv
// Bench for fv_core_if_queue_sched: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against an occupancy model.
module tb_fv_core_if_queue_sched;
  localparam int MI = 2;
  localparam int DP = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_, stall, kill, kill_is_cf, drain_req;
  logic [MI-1:0] gen_valid, gen_ready, fetch_req, queue_push, queue_pop, is_empty;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic          proto_err;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  int m_cnt, m_st;
  bit m_err;

  fv_core_if_queue_sched #(.MAX_INSTR(MI), .DEPTH(DP), .CNT_W(CW)) dut (
    .clk(clk), .reset_(reset_), .stall(stall), .kill(kill), .kill_is_cf(kill_is_cf),
    .drain_req(drain_req), .gen_valid(gen_valid), .gen_ready(gen_ready),
    .fetch_req(fetch_req), .queue_push(queue_push), .queue_pop(queue_pop),
    .is_empty(is_empty), .count(count), .state(state), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lead_ones(input logic [MI-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MI; i++) begin
      if (v[i] && n == i) n++;
    end
    return n;
  endfunction

  function automatic bit pfx(input logic [MI-1:0] v);
    return lead_ones(v) == $countones(v);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Occupancy model: counts of instructions, masks derived as low-order runs.
  always @(negedge clk) begin
    if (chk_en) begin
      if (!reset_) begin
        m_cnt = 0; m_st = 0; m_err = 0;
        chk("rst_count", int'(count), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_err", int'(proto_err), 0);
        chk("rst_pop", int'(queue_pop), 0);
        chk("rst_empty", int'(is_empty), 3);
        chk("rst_ready", int'(gen_ready), (!stall && !drain_req) ? 3 : 0);
      end else begin
        int free, rdy_n, push_n, avail, pop_n, nc, sum;
        bit kint, acc, runl;
        logic [MI-1:0] erdy, epush, epop, eemp;
        kint  = kill && kill_is_cf;
        acc   = (m_st == 0) || (m_st == 1);
        runl  = (m_st == 1) || (m_st == 2);
        free  = DP - 1 - m_cnt;
        rdy_n = (!stall && acc && !drain_req) ? imin(free, MI) : 0;
        if (rdy_n < 0) rdy_n = 0;
        erdy   = MI'((1 << rdy_n) - 1);
        epush  = gen_valid & erdy;
        push_n = $countones(epush);
        avail  = m_cnt + push_n;
        pop_n  = (runl && !stall && !kint) ? imin(imin(lead_ones(fetch_req), avail), MI) : 0;
        epop   = MI'((1 << pop_n) - 1);
        eemp   = (!runl || kint) ? MI'(3) : MI'(~((1 << imin(avail, MI)) - 1));
        chk("count", int'(count), m_cnt);
        chk("state", int'(state), m_st);
        chk("proto_err", int'(proto_err), int'(m_err));
        chk("gen_ready", int'(gen_ready), int'(erdy));
        chk("queue_push", int'(queue_push), int'(epush));
        chk("queue_pop", int'(queue_pop), int'(epop));
        chk("is_empty", int'(is_empty), int'(eemp));
        sum = avail - pop_n;
        nc  = kint ? (stall ? 0 : push_n) : (!stall ? sum : m_cnt);
        if (!pfx(gen_valid) || !pfx(fetch_req) || (!kint && !stall && (sum > DP - 1 || sum < 0)))
          m_err = 1;
        case (m_st)
          0: if (drain_req) m_st = 2;
             else if (!kint && (nc >= MI || (nc != 0 && gen_valid == 0))) m_st = 1;
          1: if (drain_req) m_st = 2; else if (kint) m_st = 0;
          2: if (kint || (!stall && sum == 0)) m_st = 3;
          default: m_st = 3;
        endcase
        m_cnt = nc;
      end
    end
  end

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic mid(); @(negedge clk); #1; endtask

  initial begin
    reset_ = 1'b0; stall = 1'b0; kill = 1'b0; kill_is_cf = 1'b0; drain_req = 1'b0;
    gen_valid = 2'b11; fetch_req = 2'b11;
    chk_en = 1'b1;
    mid();
    chk("L_rst_count", int'(count), 0);
    chk("L_rst_ready", int'(gen_ready), 3);
    chk("L_rst_empty", int'(is_empty), 3);
    // Reset and refill
    cyc(); reset_ = 1'b1;
    mid(); chk("L1_push", int'(queue_push), 3); chk("L1_pop", int'(queue_pop), 0);
    chk("L1_empty", int'(is_empty), 3);
    cyc(); mid();
    chk("L1_count", int'(count), 2); chk("L1_state", int'(state), 1);
    chk("L1_bypass_pop", int'(queue_pop), 3);
    // Fill to capacity
    cyc(); fetch_req = 2'b00; mid(); chk("L2_c2", int'(count), 2);
    cyc(); mid(); chk("L2_c4", int'(count), 4);
    cyc(); mid(); chk("L2_c6", int'(count), 6); chk("L2_push01", int'(queue_push), 1);
    cyc(); mid(); chk("L2_c7", int'(count), 7); chk("L2_ready0", int'(gen_ready), 0);
    chk("L2_err", int'(proto_err), 0);
    // Stall
    cyc(); gen_valid = 2'b00; fetch_req = 2'b11; mid();
    cyc(); mid(); chk("L3_c5", int'(count), 5);
    cyc(); stall = 1'b1; gen_valid = 2'b11; mid();
    chk("L3_c3", int'(count), 3); chk("L3_push", int'(queue_push), 0);
    chk("L3_pop", int'(queue_pop), 0);
    cyc(); mid(); chk("L3_hold", int'(count), 3);
    // Kill filtering
    cyc(); stall = 1'b0; fetch_req = 2'b00; mid(); chk("L4_push", int'(queue_push), 3);
    cyc(); kill = 1'b1; gen_valid = 2'b00; mid(); chk("L4_c5", int'(count), 5);
    cyc(); kill_is_cf = 1'b1; gen_valid = 2'b01; fetch_req = 2'b11; mid();
    chk("L4_nocf_count", int'(count), 5); chk("L4_nocf_state", int'(state), 1);
    chk("L4_kill_pop", int'(queue_pop), 0);
    cyc(); kill = 1'b0; kill_is_cf = 1'b0; gen_valid = 2'b11; fetch_req = 2'b00; mid();
    chk("L4_count", int'(count), 1); chk("L4_state", int'(state), 0);
    // Drain
    cyc(); drain_req = 1'b1; fetch_req = 2'b11; mid();
    chk("L5_c3", int'(count), 3); chk("L5_ready", int'(gen_ready), 0);
    chk("L5_pop11", int'(queue_pop), 3);
    cyc(); mid(); chk("L5_c1", int'(count), 1); chk("L5_drain", int'(state), 2);
    chk("L5_pop01", int'(queue_pop), 1);
    cyc(); mid(); chk("L5_c0", int'(count), 0); chk("L5_done", int'(state), 3);
    chk("L5_empty", int'(is_empty), 3);
    // Protocol error
    cyc(); reset_ = 1'b0; drain_req = 1'b0; gen_valid = 2'b00; fetch_req = 2'b00; mid();
    chk("L6_rst_state", int'(state), 0);
    cyc(); reset_ = 1'b1; gen_valid = 2'b10; mid(); chk("L6_err0", int'(proto_err), 0);
    cyc(); gen_valid = 2'b00; mid(); chk("L6_err1", int'(proto_err), 1);
    cyc(); mid(); chk("L6_held", int'(proto_err), 1);
    cyc(); reset_ = 1'b0; mid(); chk("L6_cleared", int'(proto_err), 0);
    cyc(); reset_ = 1'b1;
    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      int r;
      cyc();
      stall      = ($urandom_range(0, 4) == 0);
      kill       = ($urandom_range(0, 7) == 0);
      kill_is_cf = $urandom_range(0, 1);
      if (!drain_req) drain_req = ($urandom_range(0, 60) == 0);
      else            drain_req = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 2);
      gen_valid = ($urandom_range(0, 300) == 0) ? 2'b10 : MI'((1 << r) - 1);
      r = $urandom_range(0, 2);
      fetch_req = ($urandom_range(0, 300) == 0) ? 2'b10 : MI'((1 << r) - 1);
      reset_ = !(($urandom_range(0, 250) == 0) || (state == 2'd3 && $urandom_range(0, 3) == 0));
    end
    cyc();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
